param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, count/data/limit width (legal range 2..32).
REQ-002 SHALL provide parameter RESET_VAL, default 0, value of count after reset (SHALL be <= 2^WIDTH-1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; no step when low.
REQ-006 load  input  1  synchronous load of data.
REQ-007 data  input  WIDTH  load value.
REQ-008 up_down  input  1  direction: 1 = up, 0 = down.
REQ-009 limit  input  WIDTH  upper terminal value; lower terminal is 0.
REQ-010 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-011 clr_flags  input  1  synchronous clear of ovf/unf.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 wrap_pulse  output  1  registered single-cycle wrap indication.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 unf  output  1  sticky underflow flag.
REQ-016 done  output  1  one-shot terminal reached, held until load.

Function
REQ-017 Priority per edge SHALL be: load > step (en=1, done=0) > hold.
REQ-018 Load SHALL set count to min(data, limit) and clear done; no flag or wrap_pulse from a load.
REQ-019 Up step with count < limit SHALL set count to count+1.
REQ-020 Up step with count >= limit: wrap -> count 0, ovf set, wrap_pulse 1; saturate -> count = limit, ovf set; one-shot -> count = limit, done set.
REQ-021 Down step with count > 0 SHALL set count to count-1, including when count > limit (limit lowered at runtime).
REQ-022 Down step with count == 0: wrap -> count = limit, unf set, wrap_pulse 1; saturate -> hold 0, unf set; one-shot -> hold 0, done set.
REQ-023 One-shot: the step that makes count equal the terminal value (limit up, 0 down) SHALL also set done on that same edge.
REQ-024 While done=1, en SHALL be ignored and count held; mode change does not clear done.
REQ-025 wrap_pulse SHALL be high exactly for the cycle following a wrapping edge, coincident with the wrapped count; back-to-back wraps keep it high.
REQ-026 ovf/unf SHALL stay set until clr_flags; set and clr_flags on the same edge -> set wins.
REQ-027 limit = 0: count SHALL remain 0; up/down steps in wrap mode SHALL assert wrap_pulse and ovf/unf each step.
REQ-028 All arithmetic SHALL be WIDTH-bit unsigned; no internal carry escapes except via flags.
REQ-029 Outputs SHALL be glitch-free registered values; no combinational path from inputs to outputs.

Reset
REQ-030 reset high SHALL asynchronously force count = RESET_VAL, wrap_pulse = 0, ovf = 0, unf = 0, done = 0.
REQ-031 reset mid-operation SHALL abort any step or load in flight; first step occurs on the first rising edge with reset low.
REQ-032 reset SHALL override load, en and clr_flags.

Verification
REQ-033 WIDTH=8, limit=5, mode=00, up, en=1 from 0 -> count 1,2,3,4,5,0; wrap_pulse high only with the 0; ovf=1.
REQ-034 limit=5, mode=01, down from load data=2 -> count 1,0,0,0; unf=1; wrap_pulse never high.
REQ-035 mode=10, up from 3 with limit=6 -> count 4,5,6 then held; done rises with count=6; load data=9 -> count 6, done 0.
REQ-036 count=200, limit lowered to 100, up step -> count 0 (wrap) ; down step from 200 instead -> count 199.
REQ-037 ovf=1, clr_flags=1 on same edge as overflowing wrap -> ovf stays 1; next clr_flags alone -> ovf 0.
REQ-038 reset asserted between edges while counting at 7 -> count = RESET_VAL immediately, all flags 0, no pulse.

Source files
------------

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable limit, wrap/saturate/one-shot modes.
// Ports: clk, reset, en, load, data, up_down, limit, mode, clr_flags in;
//        count, wrap_pulse, ovf, unf, done out (all registered).
module param_updown_counter #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up_down,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             wrap_pulse,
  output logic             ovf,
  output logic             unf,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             done_q, done_d;

  logic is_sat;
  logic is_os;

  // Mode 11 falls back to wrap behaviour.
  assign is_sat = (mode == 2'b01);
  assign is_os  = (mode == 2'b10);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    // A flag set later in this block overrides the clear.
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    done_d  = done_q;

    if (load) begin
      count_d = (data > limit) ? limit : data;
      done_d  = 1'b0;
    end else if (en && !done_q) begin
      if (up_down) begin
        if (count_q < limit) begin
          count_d = count_q + ONE;
          if (is_os && (count_q + ONE == limit))
            done_d = 1'b1;
        end else if (is_sat) begin
          count_d = limit;
          ovf_d   = 1'b1;
        end else if (is_os) begin
          count_d = limit;
          done_d  = 1'b1;
        end else begin
          count_d = ZERO;
          ovf_d   = 1'b1;
          wrap_d  = 1'b1;
        end
      end else begin
        // Decrements even when count sits above a lowered limit.
        if (count_q != ZERO) begin
          count_d = count_q - ONE;
          if (is_os && (count_q == ONE))
            done_d = 1'b1;
        end else if (is_sat) begin
          unf_d = 1'b1;
        end else if (is_os) begin
          done_d = 1'b1;
        end else begin
          count_d = limit;
          unf_d   = 1'b1;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign done       = done_q;

endmodule
